adder_share_arb: RTL and testbench

Shares one `adder_generic` instance between `NREQ` requesters (DLX ALU, branch-target and address-generation paths) so that only one physical adder is built. Each requester presents operands with a valid/ready handshake. A round-robin arbiter grants at most one requester per cycle. The granted operands drive the adder combinationally, and the sum, carry and overflow are captured in a one-entry result register tagged with the requester index.

---
 rtl/adder_share_pkg.sv | 32 +++
 rtl/adder_generic.sv | 16 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/adder_share_arb.sv | 134 +++++++++++++
 tb/tb_adder_share_arb.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/adder_share_pkg.sv
// rtl/adder_share_pkg.sv - shared types and helpers for the shared-adder arbiter
package adder_share_pkg;

    // Arbiter pointer and grant index width; covers up to 8 requesters.
    localparam int PTR_W   = 3;
    // Field widths of the response record at the default configuration.
    localparam int RSP_N   = 32;
    localparam int RSP_IDW = 3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    typedef struct packed {
        logic [RSP_IDW-1:0] id;
        logic [RSP_N-1:0]   y;
        logic               cout;
        logic               ovf;
    } rsp_t;

    // Index idx positions after ptr, wrapping modulo nreq (ptr, idx < nreq).
    function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] ptr,
                                                 input logic [PTR_W-1:0] idx,
                                                 input int nreq);
        int s;
        s = int'(ptr) + int'(idx);
        if (s >= nreq) s = s - nreq;
        return s[PTR_W-1:0];
    endfunction

endpackage

// File: rtl/adder_generic.sv
// rtl/adder_generic.sv - N-bit adder with carry-in, carry-out and signed overflow
module adder_generic #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] y,
    output logic         cout,
    output logic         ovf
);

    assign {cout, y} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    assign ovf = (a[N-1] & b[N-1] & ~y[N-1]) | (~a[N-1] & ~b[N-1] & y[N-1]);

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot arbiter scanning upward from ptr
module rr_arbiter
    import adder_share_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic             en,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [PTR_W-1:0] gnt_idx
);

    logic [PTR_W-1:0] cand;
    logic             found;

    // Scan candidates ptr, ptr+1, ... and grant the first valid one.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = rr_next(ptr, PTR_W'(k), NREQ);
            for (int j = 0; j < NREQ; j++) begin
                if (en && !found && cand == PTR_W'(j) && req[j]) begin
                    gnt[j]  = 1'b1;
                    gnt_idx = cand;
                    found   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/adder_share_arb.sv
// rtl/adder_share_arb.sv - one adder shared by NREQ requesters; option ADDER_SHARE_OVF_STICKY_EN
module adder_share_arb
    import adder_share_pkg::*;
#(
    parameter int N    = 32,
    parameter int NREQ = 2,
    parameter int IDW  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [IDW-1:0]  rsp_id,
    output logic [N-1:0]    rsp_y,
    output logic            rsp_cout,
    output logic            rsp_ovf
`ifdef ADDER_SHARE_OVF_STICKY_EN
    ,
    input  logic            ovf_clr,
    output logic [NREQ-1:0] ovf_sticky
`endif
);

    state_t           state;
    state_t           state_nxt;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] gnt_idx;
    logic             can_accept;
    logic             req_xfer;
    logic             rsp_xfer;
    logic [N-1:0]     add_a;
    logic [N-1:0]     add_b;
    logic             add_cin;
    logic [N-1:0]     sum_y;
    logic             sum_cout;
    logic             sum_ovf;

    assign rsp_valid  = (state == FULL);
    assign can_accept = !rsp_valid || rsp_ready;
    assign req_xfer   = |req_ready;
    assign rsp_xfer   = rsp_valid && rsp_ready;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (req_valid),
        .en      (can_accept),
        .ptr     (ptr),
        .gnt     (req_ready),
        .gnt_idx (gnt_idx)
    );

    // Route the granted operands to the adder; zeros when idle to avoid toggling.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                add_a   = req_a[i*N +: N];
                add_b   = req_b[i*N +: N];
                add_cin = req_cin[i];
            end
        end
    end

    adder_generic #(.N(N)) u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .y    (sum_y),
        .cout (sum_cout),
        .ovf  (sum_ovf)
    );

    // Output state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    // Next state: fill on grant, drain on consume without a refill.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (req_xfer) state_nxt = FULL;
            FULL:    if (rsp_xfer && !req_xfer) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // Capture the result with its owner tag; hold otherwise for stable outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_id   <= '0;
            rsp_y    <= '0;
            rsp_cout <= 1'b0;
            rsp_ovf  <= 1'b0;
        end else if (req_xfer) begin
            rsp_id   <= IDW'(gnt_idx);
            rsp_y    <= sum_y;
            rsp_cout <= sum_cout;
            rsp_ovf  <= sum_ovf;
        end
    end

    // Advance the round-robin pointer past the requester just served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           ptr <= '0;
        else if (req_xfer) ptr <= rr_next(gnt_idx, PTR_W'(1), NREQ);
    end

`ifdef ADDER_SHARE_OVF_STICKY_EN
    logic [NREQ-1:0] sticky_nxt;

    // Clear first, then OR in the new overflow so a same-cycle set wins.
    always_comb begin
        sticky_nxt = ovf_clr ? '0 : ovf_sticky;
        for (int j = 0; j < NREQ; j++) begin
            if (rsp_xfer && rsp_ovf && rsp_id == IDW'(j)) sticky_nxt[j] = 1'b1;
        end
    end

    // Per-requester sticky overflow flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_sticky <= '0;
        else     ovf_sticky <= sticky_nxt;
    end
`endif

endmodule

// File: tb/tb_adder_share_arb.sv
// tb/tb_adder_share_arb.sv - self-checking bench for adder_share_arb
module tb_adder_share_arb;
    import adder_share_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [31:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
    logic        cin0 = 1'b0, cin1 = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [2:0]  rsp_id;
    logic [31:0] rsp_y;
    logic        rsp_cout;
    logic        rsp_ovf;
    logic        ovf_clr = 1'b0;
`ifdef ADDER_SHARE_OVF_STICKY_EN
    logic [1:0]  ovf_sticky;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        rsp_t        exp;
    } vec_t;

    vec_t vecs[8];

    adder_share_arb #(.N(32), .NREQ(2), .IDW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     ({a1, a0}),
        .req_b     ({b1, b0}),
        .req_cin   ({cin1, cin0}),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf)
`ifdef ADDER_SHARE_OVF_STICKY_EN
        ,
        .ovf_clr   (ovf_clr),
        .ovf_sticky(ovf_sticky)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rsp_bits();
        return {26'd0, rsp_valid, rsp_id, rsp_y, rsp_cout, rsp_ovf};
    endfunction

    function automatic logic [63:0] exp_bits(input logic v, input logic [2:0] id,
                                             input logic [31:0] y, input logic c, input logic o);
        return {26'd0, v, id, y, c, o};
    endfunction

    initial begin
        vecs[0] = '{0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, '{3'd0, 32'h8000_0000, 1'b0, 1'b1}};
        vecs[1] = '{1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, '{3'd1, 32'h0000_0000, 1'b1, 1'b0}};
        vecs[2] = '{0, 32'h8000_0000, 32'h8000_0000, 1'b0, '{3'd0, 32'h0000_0000, 1'b1, 1'b1}};
        vecs[3] = '{1, 32'h0000_0001, 32'h0000_0002, 1'b1, '{3'd1, 32'h0000_0004, 1'b0, 1'b0}};
        vecs[4] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, '{3'd0, 32'hFFFF_FFFF, 1'b1, 1'b0}};
        vecs[5] = '{1, 32'h1234_5678, 32'h1111_1111, 1'b0, '{3'd1, 32'h2345_6789, 1'b0, 1'b0}};
        vecs[6] = '{0, 32'h0000_0000, 32'h0000_0000, 1'b0, '{3'd0, 32'h0000_0000, 1'b0, 1'b0}};
        vecs[7] = '{1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, '{3'd1, 32'hFFFF_FFFF, 1'b0, 1'b1}};

        // Reset state.
        #1;
        chk("reset_outputs", rsp_bits(), exp_bits(1'b0, 3'd0, 32'd0, 1'b0, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("idle_ready", {62'd0, req_ready}, 64'd0);

        // Single-request vectors.
        for (int i = 0; i < 8; i++) begin
            a0 = '0; b0 = '0; cin0 = 1'b0;
            a1 = '0; b1 = '0; cin1 = 1'b0;
            if (vecs[i].id == 0) begin
                req_valid = 2'b01;
                a0 = vecs[i].a; b0 = vecs[i].b; cin0 = vecs[i].cin;
            end else begin
                req_valid = 2'b10;
                a1 = vecs[i].a; b1 = vecs[i].b; cin1 = vecs[i].cin;
            end
            #1;
            chk($sformatf("vec%0d_ready", i), {62'd0, req_ready}, {62'd0, req_valid});
            tick();
            req_valid = 2'b00;
            chk($sformatf("vec%0d_rsp", i), rsp_bits(), {26'd0, 1'b1, vecs[i].exp});
        end

        // Fairness: both requesters continuously valid.
        a0 = 32'd10;  b0 = 32'd20;  cin0 = 1'b0;
        a1 = 32'd100; b1 = 32'd200; cin1 = 1'b0;
        req_valid = 2'b11;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("fair%0d_ready", c), {62'd0, req_ready},
                (c % 2 == 0) ? 64'd1 : 64'd2);
            tick();
            chk($sformatf("fair%0d_rsp", c), rsp_bits(),
                (c % 2 == 0) ? exp_bits(1'b1, 3'd0, 32'd30, 1'b0, 1'b0)
                             : exp_bits(1'b1, 3'd1, 32'd300, 1'b0, 1'b0));
        end

        // Backpressure: result held, no grants.
        rsp_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("bp%0d_ready", c), {62'd0, req_ready}, 64'd0);
            chk($sformatf("bp%0d_hold", c), rsp_bits(), exp_bits(1'b1, 3'd1, 32'd300, 1'b0, 1'b0));
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", {62'd0, req_ready}, 64'd1);
        tick();
        chk("bp_release_rsp", rsp_bits(), exp_bits(1'b1, 3'd0, 32'd30, 1'b0, 1'b0));

        // Asynchronous reset while a result is held.
        req_valid = 2'b00;
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", rsp_bits(), exp_bits(1'b0, 3'd0, 32'd0, 1'b0, 1'b0));
        tick();
        rst = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("post_reset_grant", {62'd0, req_ready}, 64'd1);
        tick();
        req_valid = 2'b00;
        chk("post_reset_rsp", rsp_bits(), exp_bits(1'b1, 3'd0, 32'd30, 1'b0, 1'b0));

`ifdef ADDER_SHARE_OVF_STICKY_EN
        // Sticky overflow on requester 1, then clear.
        a1 = 32'h8000_0000; b1 = 32'h8000_0000; cin1 = 1'b0;
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        chk("sticky_before_xfer", {62'd0, ovf_sticky}, 64'd0);
        tick();
        chk("sticky_set", {62'd0, ovf_sticky}, 64'd2);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("sticky_clr", {62'd0, ovf_sticky}, 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
